// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolution loop scheduler.
//   - K_DEFAULT / AW_DEFAULT: default kernel edge and address/dimension width.
//   - state_e: scheduler FSM states.
//   - tap_idx_t: one tap position (row, col, kr, kc) at the default width.
package conv_pkg;

    localparam int K_DEFAULT  = 3;
    localparam int AW_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [AW_DEFAULT-1:0] row;
        logic [AW_DEFAULT-1:0] col;
        logic [AW_DEFAULT-1:0] kr;
        logic [AW_DEFAULT-1:0] kc;
    } tap_idx_t;

endpackage

// File: rtl/loop_counter.sv
// loop_counter: bounded up-counter used as one level of a nested loop.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear_i      : synchronous clear to 0 (wins over en_i)
//   en_i         : advance by one this cycle (deasserted = hold)
//   bound_i      : last value of the loop (inclusive), runtime
//   count_o      : current loop index
//   wrap_o       : high when an enabled step wraps bound_i back to 0;
//                  used as the enable of the next-outer loop level
module loop_counter #(
    parameter int AW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          en_i,
    input  logic [AW-1:0] bound_i,
    output logic [AW-1:0] count_o,
    output logic          wrap_o
);

    logic [AW-1:0] count_q;
    logic [AW-1:0] count_d;

    // Wrap is qualified by en_i so that chaining wrap -> en gives a
    // carry that only fires on the step that actually rolls over.
    assign wrap_o  = en_i && (count_q == bound_i);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = wrap_o ? '0 : count_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/conv_loop_ctrl.sv
// conv_loop_ctrl: loop scheduler for a KxK valid convolution over a
// runtime-sized W x H feature map. Iterates row / col / kr / kc (kc fastest),
// issuing one input read address per tap and one output write per pixel.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : start request, accepted only in IDLE
//   cfg_width/height    : map size, sampled on the accepted start
//   stall               : backpressure; freezes iteration while high
//   rd_valid, rd_addr   : tap read strobe and address (row+kr)*W + col+kc
//   acc_clear, acc_last : first / last tap of an output pixel
//   wr_valid, wr_addr   : completed pixel write, address row*OW + col
//   busy, done, err     : status; err is sticky until the next accepted start
//   dbg_state           : current FSM state
//
// Handshake: a tap is transferred on every cycle where rd_valid is high;
// rd_valid = (state == RUN) && !stall, so stall acts as an inverted ready and
// the downstream never needs to hold a tap.
module conv_loop_ctrl
    import conv_pkg::*;
#(
    parameter int K  = K_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] cfg_width,
    input  logic [AW-1:0] cfg_height,
    input  logic          stall,
    output logic          rd_valid,
    output logic [AW-1:0] rd_addr,
    output logic          acc_clear,
    output logic          acc_last,
    output logic          wr_valid,
    output logic [AW-1:0] wr_addr,
    output logic          busy,
    output logic          done,
    output logic          err,
    output state_e        dbg_state
);

    localparam logic [AW-1:0] K_VAL  = AW'(K);
    localparam logic [AW-1:0] K_LAST = AW'(K - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] w_q;
    logic [AW-1:0] ow_q;
    logic [AW-1:0] oh_q;
    logic          err_q;
    logic          wr_valid_q;
    logic [AW-1:0] wr_addr_q;

    logic          start_ok;
    logic          cfg_bad;
    logic          tap_accept;
    logic          tap_first;
    logic          tap_last;

    logic [AW-1:0] kc, kr, col, row;
    logic          kc_wrap, kr_wrap, col_wrap, row_wrap;
    logic [AW-1:0] pix_addr;

    assign start_ok   = (state_q == ST_IDLE) && start;
    assign cfg_bad    = (cfg_width < K_VAL) || (cfg_height < K_VAL);
    assign tap_accept = (state_q == ST_RUN) && !stall;

    // ------------------------------------------------------------------
    // Nested loop counters, kc fastest. Each level steps when the level
    // inside it wraps; row wrapping marks the final tap of the layer.
    // ------------------------------------------------------------------
    loop_counter #(.AW(AW)) u_kc (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (start_ok),
        .en_i    (tap_accept),
        .bound_i (K_LAST),
        .count_o (kc),
        .wrap_o  (kc_wrap)
    );

    loop_counter #(.AW(AW)) u_kr (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (start_ok),
        .en_i    (kc_wrap),
        .bound_i (K_LAST),
        .count_o (kr),
        .wrap_o  (kr_wrap)
    );

    loop_counter #(.AW(AW)) u_col (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (start_ok),
        .en_i    (kr_wrap),
        .bound_i (ow_q - AW'(1)),
        .count_o (col),
        .wrap_o  (col_wrap)
    );

    loop_counter #(.AW(AW)) u_row (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (start_ok),
        .en_i    (col_wrap),
        .bound_i (oh_q - AW'(1)),
        .count_o (row),
        .wrap_o  (row_wrap)
    );

    // ------------------------------------------------------------------
    // Address datapath. Purely combinational from the counters, so the
    // read address naturally holds while stalled. Truncating AW-bit math.
    // ------------------------------------------------------------------
    assign tap_first = (kc == '0) && (kr == '0);
    assign tap_last  = (kc == K_LAST) && (kr == K_LAST);
    assign rd_addr   = (row + kr) * w_q + col + kc;
    assign pix_addr  = row * ow_q + col;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A too-small map has no output pixels; report and finish.
                    state_d = cfg_bad ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (row_wrap) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        rd_valid  = tap_accept;
        acc_clear = tap_accept && tap_first;
        acc_last  = tap_accept && tap_last;
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
    end

    assign err       = err_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // Configuration latch and output dimensions, captured once per layer
    // so later cfg_* changes cannot disturb a running layer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q   <= '0;
            ow_q  <= '0;
            oh_q  <= '0;
            err_q <= 1'b0;
        end else if (start_ok) begin
            w_q   <= cfg_width;
            ow_q  <= cfg_width - K_LAST;
            oh_q  <= cfg_height - K_LAST;
            err_q <= cfg_bad;
        end
    end

    // ------------------------------------------------------------------
    // Write pipeline register: loaded on the accepted last tap of a pixel,
    // presented the next cycle independent of stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            wr_valid_q <= tap_accept && tap_last;
            if (tap_accept && tap_last) begin
                wr_addr_q <= pix_addr;
            end
        end
    end

endmodule

// File: doc/conv_loop_ctrl.md
# conv_loop_ctrl

Loop scheduler for the single-layer convolution engine. It sequences the nested output-row / output-col / kernel-row / kernel-col iteration of a KxK valid convolution over a runtime-sized feature map. It emits one input-buffer read address per tap, accumulator clear/last strobes, and one output write address per completed pixel. It sits between the top-level start/done handshake and the PE accumulator / SRAM address ports. It is built from four chained instances of a bounded loop counter.

## Interface
- K, default 3: kernel edge; taps per output pixel = K*K.
- AW, default 16: address and dimension width.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; accepted only in IDLE.
- cfg_width  in  AW  input map width W; sampled on the accepted start.
- cfg_height  in  AW  input map height H; sampled on the accepted start.
- stall  in  1  datapath backpressure; freezes iteration while high.
- rd_valid  out  1  rd_addr is a live tap read.
- rd_addr  out  AW  (row+kr)*W + (col+kc), truncated to AW bits.
- acc_clear  out  1  high with tap (0,0) of each output pixel.
- acc_last  out  1  high with tap (K-1,K-1) of each output pixel.
- wr_valid  out  1  one-cycle pulse; a pixel has completed.
- wr_addr  out  AW  row*OW + col of the completed pixel.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  sticky config error; cleared on the next accepted start.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: on start go to RUN, latch W and H, zero all counters, clear err.
  - Bad config: if W<K or H<K on start, go IDLE->DONE instead and set err.
  - RUN: iterate taps. When the final tap of the final pixel is accepted, go to FLUSH.
  - FLUSH: lasts exactly 1 cycle, then DONE.
  - DONE: lasts exactly 1 cycle, then IDLE.
- Output dimensions: OW = W-K+1, OH = H-K+1, computed once at start into registers.
- Counter order, fastest first: kc in [0,K-1], kr in [0,K-1], col in [0,OW-1], row in [0,OH-1].
  - Each counter wraps to 0 and carries into the next when it reaches its bound on an accepted tap.
- A tap is accepted when state==RUN and stall==0.
  - rd_valid = RUN & !stall.
  - acc_clear and acc_last are gated by rd_valid.
- Stall: all counters hold, and rd_addr holds its value.
- wr_valid / wr_addr come from a pipeline register loaded on the accepted acc_last tap.
  - The pulse appears on the following cycle regardless of stall.
  - For the final pixel, that cycle is FLUSH.
- start outside IDLE is ignored.
- cfg_* changes after the accepted start have no effect.
- Arithmetic: rd_addr and wr_addr use an AW-bit multiply-add truncated to AW bits. No saturation. Wrap-around beyond 2^AW is the caller's problem.
- Reset (async, any state) forces:
  - state to IDLE;
  - all counters, latched dims and the write register to 0;
  - all outputs to 0.
  - A mid-run reset abandons the layer with no done pulse.

## Timing
- Output values at reset: every output is 0.
- Accepted start at edge n: RUN from cycle n+1, issuing tap (0,0) of pixel (0,0) with acc_clear=1.
- Unstalled run length: OW*OH*K*K RUN cycles, then 1 FLUSH cycle, then 1 DONE cycle.
- Each stall cycle extends RUN by exactly one cycle.
- Latency from the last tap of a pixel to wr_valid for that pixel: 1 cycle.
- When K==1, acc_clear and acc_last are high on the same tap.

## Structure
- Shared package conv_pkg holds:
  - the state enum (IDLE/RUN/FLUSH/DONE);
  - the K and AW defaults;
  - the tap-index typedef.
- Sub-module loop_counter: AW-bit counter with:
  - clear;
  - enable (the inverse of hold);
  - a runtime bound input;
  - a wrap output.
- conv_loop_ctrl instantiates four loop_counter instances chained through wrap, plus the FSM and the address datapath.

## Test plan
- W=H=4, K=3, no stall, start at edge 0:
  - first 9 rd_addr = 0,1,2,4,5,6,8,9,10;
  - 36 rd_valid cycles (1..36);
  - wr_addr 0,1,2,3 in order, the last one in FLUSH at cycle 37;
  - done at cycle 38;
  - busy high for cycles 1..38.
- Same config with stall high for 3 cycles mid-pixel:
  - rd_addr frozen while stalled;
  - done delayed by exactly 3 cycles;
  - address sequence unchanged.
- W=H=3: a single output pixel, 9 taps, acc_clear on the first tap, acc_last on the ninth, wr_addr=0.
- W=2, H=5 at start: IDLE->DONE, err=1, no rd_valid.
  - A following valid start clears err.
- start pulsed while in RUN: ignored.
  - cfg_width changed mid-run: addresses still use the latched W.
- rst asserted at cycle 10 of RUN: all outputs 0 immediately, state IDLE, no done.
  - A new start runs a full layer correctly.
